// File: rtl/exmem_bram_arbiter.sv
// Shares one single-port user BRAM between the Wishbone slave path and the FIR
// engine: round-robin grant, fixed wait-state interval, one-cycle access, then ack.
module exmem_bram_arbiter #(
    parameter int unsigned DELAYS    = 10,
    parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
    parameter int unsigned AW        = 10
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          fir_req_i,
    input  logic          fir_we_i,
    input  logic [AW-1:0] fir_addr_i,
    input  logic [31:0]   fir_wdata_i,
    output logic          fir_gnt_o,
    output logic [31:0]   fir_rdata_o,
    output logic          bram_en_o,
    output logic [3:0]    bram_we_o,
    output logic [31:0]   bram_a_o,
    output logic [31:0]   bram_di_o,
    input  logic [31:0]   bram_do_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic OWN_WB  = 1'b0;
    localparam logic OWN_FIR = 1'b1;

    localparam int unsigned   CW       = (DELAYS > 1) ? $clog2(DELAYS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAYS - 1);

    // Window bounds carry a 33rd bit so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << AW);

    logic [1:0]    state_q;
    logic          owner_q;
    logic          last_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdata_q;

    logic [32:0]   adr_ext;
    logic          wb_req;
    logic [AW-1:0] wb_word;
    logic          grant_fir;

    assign adr_ext   = {1'b0, wbs_adr_i};
    assign wb_req    = wbs_stb_i & wbs_cyc_i & (adr_ext >= WIN_LO) & (adr_ext < WIN_HI);
    assign wb_word   = AW'((wbs_adr_i - ADDR_BASE) >> 2);

    // On a tie the requester that was not served last wins.
    assign grant_fir = fir_req_i & (~wb_req | (last_q == OWN_WB));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            owner_q <= OWN_WB;
            last_q  <= OWN_FIR;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb_req | fir_req_i) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                        owner_q <= grant_fir ? OWN_FIR : OWN_WB;
                        last_q  <= grant_fir ? OWN_FIR : OWN_WB;
                        if (grant_fir) begin
                            addr_q  <= fir_addr_i;
                            we_q    <= fir_we_i;
                            sel_q   <= 4'hF;
                            wdata_q <= fir_wdata_i;
                        end else begin
                            addr_q  <= wb_word;
                            we_q    <= wbs_we_i;
                            sel_q   <= wbs_sel_i;
                            wdata_q <= wbs_dat_i;
                        end
                    end
                end
                S_WAIT: begin
                    // A dropped Wishbone cycle wins over the final wait tick.
                    if (owner_q == OWN_WB && !wbs_cyc_i) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ACCESS: state_q <= S_DONE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value held, which would otherwise infer a latch.
    always_comb begin
        bram_en_o   = 1'b0;
        bram_we_o   = 4'h0;
        bram_a_o    = '0;
        bram_di_o   = '0;
        wbs_ack_o   = 1'b0;
        wbs_dat_o   = '0;
        fir_gnt_o   = 1'b0;
        fir_rdata_o = '0;
        case (state_q)
            S_ACCESS: begin
                bram_en_o = 1'b1;
                bram_we_o = we_q ? sel_q : 4'h0;
                bram_a_o  = 32'(addr_q);
                bram_di_o = wdata_q;
            end
            S_DONE: begin
                if (owner_q == OWN_WB) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = we_q ? 32'h0 : bram_do_i;
                end else begin
                    fir_gnt_o   = 1'b1;
                    fir_rdata_o = we_q ? 32'h0 : bram_do_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exmem_bram_arbiter.sv
// Self-checking bench for exmem_bram_arbiter: directed vectors, multi-cycle
// corner sequences and a randomized phase against a transaction-level model.
module tb_exmem_bram_arbiter;

    localparam int          DELAYS = 10;
    localparam int          AW     = 10;
    localparam logic [31:0] BASE   = 32'h3800_0000;

    logic          clk;
    logic          rst;
    logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_dat_i, wbs_adr_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          fir_req_i, fir_we_i;
    logic [AW-1:0] fir_addr_i;
    logic [31:0]   fir_wdata_i;
    logic          fir_gnt_o;
    logic [31:0]   fir_rdata_o;
    logic          bram_en_o;
    logic [3:0]    bram_we_o;
    logic [31:0]   bram_a_o, bram_di_o;
    logic [31:0]   bram_do = '0;

    int n_checks = 0;
    int n_errors = 0;

    exmem_bram_arbiter #(.DELAYS(DELAYS), .ADDR_BASE(BASE), .AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .fir_req_i(fir_req_i), .fir_we_i(fir_we_i), .fir_addr_i(fir_addr_i),
        .fir_wdata_i(fir_wdata_i), .fir_gnt_o(fir_gnt_o), .fir_rdata_o(fir_rdata_o),
        .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_a_o(bram_a_o),
        .bram_di_o(bram_di_o), .bram_do_i(bram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single-port BRAM: byte-enabled writes, registered read data.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_idx;
    assign mem_idx = bram_a_o[AW-1:0];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            mem_ready <= 1'b1;
        end else if (bram_en_o) begin
            if (|bram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bram_we_o[b]) mem[mem_idx][8*b +: 8] <= bram_di_o[8*b +: 8];
            end else begin
                bram_do <= mem[mem_idx];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_dat_i = 0; wbs_adr_i = 0;
        fir_req_i = 0; fir_we_i = 0; fir_addr_i = 0; fir_wdata_i = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ctl"}, {26'h0, bram_en_o, bram_we_o, wbs_ack_o}, 32'h0);
        check({tag, " gnt"}, {31'h0, fir_gnt_o}, 32'h0);
        check({tag, " data"}, bram_a_o | bram_di_o | wbs_dat_o | fir_rdata_o, 32'h0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        hit;
        logic [31:0] exp_a;
        logic [31:0] exp_rd;
    } vec_t;

    // One Wishbone transfer starting now (cycle 0), observed for 30 cycles.
    task automatic wb_xfer(input vec_t v, input int idx);
        int ens, acks, en_cyc, ack_cyc;
        logic [31:0] a_s, di_s, rd_s;
        logic [3:0]  we_s;
        string tag;
        tag = $sformatf("vec%0d", idx);
        ens = 0; acks = 0; en_cyc = -1; ack_cyc = -1;
        a_s = 0; di_s = 0; rd_s = 0; we_s = 0;
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = v.we;
        wbs_adr_i = v.adr; wbs_sel_i = v.sel; wbs_dat_i = v.dat;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bram_en_o) begin
                ens++; en_cyc = k; a_s = bram_a_o; we_s = bram_we_o; di_s = bram_di_o;
            end
            if (wbs_ack_o) begin
                acks++; ack_cyc = k; rd_s = wbs_dat_o;
                wbs_stb_i = 0; wbs_cyc_i = 0;
            end
        end
        wbs_stb_i = 0; wbs_cyc_i = 0;
        check({tag, " en count"}, 32'(ens), v.hit ? 32'd1 : 32'd0);
        check({tag, " ack count"}, 32'(acks), v.hit ? 32'd1 : 32'd0);
        if (v.hit) begin
            check({tag, " en cycle"}, 32'(en_cyc), 32'(DELAYS + 1));
            check({tag, " ack cycle"}, 32'(ack_cyc), 32'(DELAYS + 2));
            check({tag, " bram_a"}, a_s, v.exp_a);
            check({tag, " bram_we"}, {28'h0, we_s}, v.we ? {28'h0, v.sel} : 32'h0);
            if (v.we) check({tag, " bram_di"}, di_s, v.dat);
            check({tag, " rdata"}, rd_s, v.exp_rd);
        end
    endtask

    // Transaction-level reference for the randomized phase.
    typedef struct {
        logic        valid;
        logic        fir;
        logic        we;
        int          word;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          done;
    } txn_t;

    logic [31:0] ref_mem [0:(1<<AW)-1];

    initial begin
        vec_t vecs[10];
        int   wb_acks[$];
        int   fir_gnts[$];
        int   ens_t, acks_t, gnts_t, en_first, gnt_cyc;
        logic [31:0] fir_rd0;

        rst = 1;
        idle_inputs();

        vecs[0] = '{1'b1, 32'h3800_0004, 4'hF, 32'h1234_5678, 1'b1, 32'd1,    32'h0};
        vecs[1] = '{1'b0, 32'h3800_0004, 4'hF, 32'h0,         1'b1, 32'd1,    32'h1234_5678};
        vecs[2] = '{1'b1, 32'h3800_0004, 4'h3, 32'hAAAA_BBBB, 1'b1, 32'd1,    32'h0};
        vecs[3] = '{1'b0, 32'h3800_0004, 4'hF, 32'h0,         1'b1, 32'd1,    32'h1234_BBBB};
        vecs[4] = '{1'b1, 32'h3000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'd0,    32'h0};
        vecs[5] = '{1'b1, 32'h3800_0FFC, 4'hF, 32'hCAFE_F00D, 1'b1, 32'd1023, 32'h0};
        vecs[6] = '{1'b0, 32'h3800_0FFE, 4'hF, 32'h0,         1'b1, 32'd1023, 32'hCAFE_F00D};
        vecs[7] = '{1'b1, 32'h3800_1000, 4'hF, 32'h1111_1111, 1'b0, 32'd0,    32'h0};
        vecs[8] = '{1'b0, 32'h37FF_FFFC, 4'hF, 32'h0,         1'b0, 32'd0,    32'h0};
        vecs[9] = '{1'b0, 32'h3800_0000, 4'hF, 32'h0,         1'b1, 32'd0,    32'h0};

        apply_reset();
        for (int i = 0; i < 10; i++) wb_xfer(vecs[i], i);

        // Both requesters held from the first cycle: strict alternation.
        apply_reset();
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h3800_0008;
        wbs_sel_i = 4'hF; wbs_dat_i = 32'h5555_AAAA;
        fir_req_i = 1; fir_we_i = 0; fir_addr_i = 10'd1;
        fir_rd0 = 0;
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            if (wbs_ack_o) wb_acks.push_back(k);
            if (fir_gnt_o) begin
                if (fir_gnts.size() == 0) fir_rd0 = fir_rdata_o;
                fir_gnts.push_back(k);
            end
        end
        idle_inputs();
        check("alt wb ack count", 32'(wb_acks.size()), 32'd2);
        check("alt fir gnt count", 32'(fir_gnts.size()), 32'd2);
        if (wb_acks.size() == 2 && fir_gnts.size() == 2) begin
            check("alt wb ack 1", 32'(wb_acks[0]), 32'(DELAYS + 2));
            check("alt fir gnt 1", 32'(fir_gnts[0]), 32'(2 * DELAYS + 5));
            check("alt wb ack 2", 32'(wb_acks[1]), 32'(3 * DELAYS + 8));
            check("alt fir gnt 2", 32'(fir_gnts[1]), 32'(4 * DELAYS + 11));
        end
        check("alt fir rdata", fir_rd0, 32'h1234_BBBB);

        // WB abort mid-wait while FIR waits behind it.
        apply_reset();
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3800_0004;
        fir_req_i = 1; fir_we_i = 1; fir_addr_i = 10'd5; fir_wdata_i = 32'h0F0F_0F0F;
        ens_t = 0; acks_t = 0; gnts_t = 0; en_first = -1; gnt_cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bram_en_o) begin
                ens_t++;
                if (en_first < 0) en_first = k;
            end
            if (wbs_ack_o) acks_t++;
            if (fir_gnt_o) begin gnts_t++; gnt_cyc = k; fir_req_i = 0; end
            if (k == 5) begin wbs_stb_i = 0; wbs_cyc_i = 0; end
        end
        idle_inputs();
        check("abort wb acks", 32'(acks_t), 32'd0);
        check("abort en count", 32'(ens_t), 32'd1);
        check("abort fir en cycle", 32'(en_first), 32'(DELAYS + 7));
        check("abort fir gnt count", 32'(gnts_t), 32'd1);
        check("abort fir gnt cycle", 32'(gnt_cyc), 32'(DELAYS + 8));

        // Abort on the very cycle the wait count expires.
        wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h3800_0010;
        wbs_sel_i = 4'hF; wbs_dat_i = 32'h7777_7777;
        ens_t = 0; acks_t = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bram_en_o) ens_t++;
            if (wbs_ack_o) acks_t++;
            if (k == DELAYS) begin wbs_stb_i = 0; wbs_cyc_i = 0; end
        end
        check("late abort en", 32'(ens_t), 32'd0);
        check("late abort ack", 32'(acks_t), 32'd0);

        // Reset in the middle of a FIR read.
        apply_reset();
        fir_req_i = 1; fir_we_i = 0; fir_addr_i = 10'd1;
        ens_t = 0; gnts_t = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bram_en_o) ens_t++;
            if (fir_gnt_o) gnts_t++;
            if (k == 4) begin rst = 1; fir_req_i = 0; end
            if (k == 5) begin check_quiet("midreset"); rst = 0; end
        end
        check("midreset en", 32'(ens_t), 32'd0);
        check("midreset gnt", 32'(gnts_t), 32'd0);

        // Randomized phase: reset left last owner = FIR, arbiter idle.
        begin
            txn_t t;
            int   idle_at, wb_gap, fir_gap, wb_seen, fir_seen;
            logic last_fir, wb_on, fir_on, wb_req_m, pick_fir, exp_en, exp_wa, exp_fg;
            logic [31:0] exp_rd;
            longint a;
            for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
            t = '{1'b0, 1'b0, 1'b0, 0, 4'h0, 32'h0, 0};
            idle_at = 0; last_fir = 1; wb_on = 0; fir_on = 0;
            wb_gap = 0; fir_gap = 0; wb_seen = 0; fir_seen = 0;
            for (int c = 0; c < 2000; c++) begin
                @(negedge clk);
                exp_en = t.valid && (c == t.done - 1);
                exp_wa = t.valid && (c == t.done) && !t.fir;
                exp_fg = t.valid && (c == t.done) && t.fir;
                exp_rd = (t.valid && c == t.done && !t.we) ? ref_mem[t.word] : 32'h0;
                check("rnd bram_en", {31'h0, bram_en_o}, {31'h0, exp_en});
                if (exp_en) begin
                    check("rnd bram_a", bram_a_o, 32'(t.word));
                    check("rnd bram_we", {28'h0, bram_we_o}, t.we ? {28'h0, t.sel} : 32'h0);
                    if (t.we) check("rnd bram_di", bram_di_o, t.wdata);
                end
                check("rnd wb ack", {31'h0, wbs_ack_o}, {31'h0, exp_wa});
                check("rnd fir gnt", {31'h0, fir_gnt_o}, {31'h0, exp_fg});
                check("rnd wb dat", wbs_dat_o, exp_wa ? exp_rd : 32'h0);
                check("rnd fir rdata", fir_rdata_o, exp_fg ? exp_rd : 32'h0);
                if (t.valid && c == t.done) begin
                    if (t.we)
                        for (int b = 0; b < 4; b++)
                            if (t.sel[b]) ref_mem[t.word][8*b +: 8] = t.wdata[8*b +: 8];
                    t.valid = 0;
                end

                if (wb_on && wbs_ack_o) begin
                    wb_on = 0; wbs_stb_i = 0; wbs_cyc_i = 0;
                    wb_gap = $urandom_range(0, 3); wb_seen++;
                end
                if (fir_on && fir_gnt_o) begin
                    fir_on = 0; fir_req_i = 0;
                    fir_gap = $urandom_range(0, 3); fir_seen++;
                end
                if (!wb_on) begin
                    if (wb_gap > 0) wb_gap--;
                    else if ($urandom_range(0, 1) == 1) begin
                        wb_on = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
                        wbs_we_i  = 1'($urandom_range(0, 1));
                        wbs_adr_i = BASE + 32'($urandom_range(64, 95)) * 4 + 32'($urandom_range(0, 3));
                        wbs_sel_i = 4'($urandom_range(0, 15));
                        wbs_dat_i = $urandom;
                    end
                end
                if (!fir_on) begin
                    if (fir_gap > 0) fir_gap--;
                    else if ($urandom_range(0, 1) == 1) begin
                        fir_on = 1; fir_req_i = 1;
                        fir_we_i    = 1'($urandom_range(0, 1));
                        fir_addr_i  = AW'($urandom_range(64, 95));
                        fir_wdata_i = $urandom;
                    end
                end

                a = longint'(wbs_adr_i);
                wb_req_m = wbs_stb_i && wbs_cyc_i && a >= longint'(BASE) &&
                           a < longint'(BASE) + 4 * (longint'(1) << AW);
                if (!t.valid && c >= idle_at && (wb_req_m || fir_req_i)) begin
                    pick_fir = fir_req_i && (!wb_req_m || !last_fir);
                    t.valid = 1;
                    t.fir   = pick_fir;
                    t.we    = pick_fir ? fir_we_i : wbs_we_i;
                    t.word  = pick_fir ? int'(fir_addr_i) : int'((a - longint'(BASE)) >> 2);
                    t.sel   = pick_fir ? 4'hF : wbs_sel_i;
                    t.wdata = pick_fir ? fir_wdata_i : wbs_dat_i;
                    t.done  = c + DELAYS + 2;
                    idle_at = c + DELAYS + 3;
                    last_fir = pick_fir;
                end
            end
            check("rnd wb served", {31'h0, wb_seen > 20}, 32'h1);
            check("rnd fir served", {31'h0, fir_seen > 20}, 32'h1);
        end

        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exmem_bram_arbiter.md
Name: exmem_bram_arbiter

Overview:
- Shares the single-port user BRAM between two requesters: the Wishbone slave path from the management SoC, and the FIR engine's memory port.
- Decodes Wishbone addresses in the user BRAM window.
- Arbitrates round-robin between the two requesters.
- Inserts a programmable wait-state interval before every access, drives the BRAM port for one cycle, then returns ack/read data to the granted requester.

Parameters:
- DELAYS, 10, wait-state cycles before each BRAM access; legal range ≥1.
- ADDR_BASE, 32'h3800_0000, byte base address of the BRAM window on Wishbone.
- AW, 10, word-address width; window size is 4*2^AW bytes.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte selects.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_adr_i  in  32  Wishbone byte address.
- wbs_ack_o  out  1  Wishbone ack, one-cycle pulse.
- wbs_dat_o  out  32  Wishbone read data.
- fir_req_i  in  1  FIR access request, level; held until fir_gnt_o.
- fir_we_i  in  1  FIR write (1) / read (0).
- fir_addr_i  in  AW  FIR word address.
- fir_wdata_i  in  32  FIR write data; always full-word write, sel=4'hF.
- fir_gnt_o  out  1  FIR completion pulse, one cycle.
- fir_rdata_o  out  32  FIR read data.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  4  BRAM byte write enables.
- bram_a_o  out  32  BRAM word address, zero-extended from AW bits.
- bram_di_o  out  32  BRAM write data.
- bram_do_i  in  32  BRAM read data; valid the cycle after en with we=0.

Behaviour:

Wishbone request decode:
- wb_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i ≥ ADDR_BASE) & (wbs_adr_i < ADDR_BASE + 4*2^AW).
- Word address = (wbs_adr_i - ADDR_BASE) >> 2, low AW bits.
- Out-of-window requests are ignored: no grant, no ack.

FSM states: IDLE, WAIT, ACCESS, DONE. Registers: owner_q (WB/FIR), last_q, cnt_q, plus latched addr, we, sel and wdata.
- IDLE:
  - If only one requester is active, grant it.
  - If both are active, grant the one not equal to last_q.
  - On grant: latch owner/addr/we/sel/wdata, set last_q <= owner, set cnt_q <= 0, go to WAIT.
  - With no request, stay in IDLE.
- WAIT:
  - cnt_q increments each cycle.
  - When cnt_q == DELAYS-1, go to ACCESS, so WAIT lasts exactly DELAYS cycles.
  - If owner=WB and wbs_cyc_i==0: abort to IDLE. No BRAM access, no ack.
  - FIR cannot abort; deasserting fir_req_i mid-access is ignored.
- ACCESS (1 cycle):
  - bram_en_o=1; bram_a_o, bram_di_o come from the latched values.
  - bram_we_o = latched sel if write, else 0.
  - Go to DONE.
- DONE (1 cycle):
  - owner WB: wbs_ack_o=1; wbs_dat_o = bram_do_i for reads, 0 for writes.
  - owner FIR: fir_gnt_o=1; fir_rdata_o = bram_do_i for reads, 0 for writes.
  - Go to IDLE.

Outputs outside the states above:
- bram_en_o, bram_we_o, bram_a_o, bram_di_o, acks and read data are all 0 outside ACCESS/DONE respectively.

Latency:
- Request seen in IDLE at cycle 0 → ACCESS at cycle DELAYS+1 → ack/gnt at cycle DELAYS+2 → IDLE at DELAYS+3.
- At least one IDLE cycle separates consecutive accesses.

Reset (synchronous, wb_rst_i=1):
- state=IDLE, last_q=FIR (WB wins the first tie), cnt_q=0, all latched regs 0.
- All outputs are 0 in the cycle after reset is sampled.
- Reset mid-operation drops the pending access with no ack/gnt and no BRAM enable.

Simultaneous events:
- A WB abort in the same cycle that cnt_q reaches DELAYS-1 still aborts (abort has priority).
- A new request arriving in DONE is not granted until the following IDLE.

Test Plan:
1. DELAYS=10: WB write adr 0x3800_0004, dat 0x1234_5678, sel 0xF at cycle 0 → cycle 11: bram_en_o=1, bram_we_o=0xF, bram_a_o=1, bram_di_o=0x1234_5678; cycle 12: wbs_ack_o=1 for exactly one cycle.
2. WB read adr 0x3800_0004 after test 1 → cycle 11: bram_en_o=1, bram_we_o=0; cycle 12: wbs_ack_o=1, wbs_dat_o=0x1234_5678. Then write sel=0x3, dat 0xAAAA_BBBB, and read back → 0x1234_BBBB.
3. fir_req_i and wb_req both held from cycle 0 after reset → WB ack at cycle 12; FIR granted at cycle 13 with fir_gnt_o at cycle 25; if both are still requesting, the next grant goes to WB, i.e. strict alternation.
4. WB read with fir_req_i high; drop wbs_cyc_i at cycle 5 → no bram_en_o, no wbs_ack_o; IDLE at cycle 6; FIR granted that cycle; fir_gnt_o at cycle 18.
5. WB request at adr 0x3000_0000 held for 30 cycles → bram_en_o and wbs_ack_o stay 0; state stays IDLE.
6. FIR read in progress; assert wb_rst_i at cycle 4 → cycle 5: all outputs 0, state IDLE; no fir_gnt_o and no bram_en_o for that access.
